// File: rtl/sar_pkg.sv
// Shared definitions for the digital SAR analog-front-end stand-in.
//   SAR_NBITS              default DAC / input resolution
//   COMP_LAT_MIN/_MAX      legal comparator latency range, in clk cycles
//   afe_state_e            track/hold state of the sample switch
//   sat_add()              offset add clamped to the code range 0..max_code
package sar_pkg;

  localparam int SAR_NBITS    = 6;
  localparam int COMP_LAT_MIN = 1;
  localparam int COMP_LAT_MAX = 4;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } afe_state_e;

  // Signed offset applied to an unsigned code, saturating at both rails.
  function automatic int sat_add(input int code, input int offset,
                                 input int max_code = (1 << SAR_NBITS) - 1);
    int sum;
    sum = code + offset;
    if (sum < 0)        return 0;
    if (sum > max_code) return max_code;
    return sum;
  endfunction

endpackage

// File: rtl/sar_cdac_decode.sv
// Capacitor-DAC switch decode and illegal-pair detect.
//   clk, rst   clock, synchronous active-high reset
//   sw, swb    per-bit DAC switch controls and their complements
//   state      track/hold state of the front end
//   dac_code   registered DAC code: bit i = 1 only for (sw=1, swb=0)
//   sw_err     sticky flag: an equal sw/swb pair was seen while holding
module sar_cdac_decode
  import sar_pkg::*;
#(
  parameter int NBITS = SAR_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] sw,
  input  logic [NBITS-1:0] swb,
  input  afe_state_e       state,
  output logic [NBITS-1:0] dac_code,
  output logic             sw_err
);

  logic [NBITS-1:0] dac_q, dac_d;
  logic             err_q, err_d;
  logic             pair_eq;

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    dac_d   = sw & ~swb;
    // Equal pairs are the all-reset phase while tracking; only illegal once holding.
    pair_eq = |(sw ~^ swb);
    err_d   = err_q | (pair_eq && (state == HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_q <= '0;
      err_q <= 1'b0;
    end else begin
      dac_q <= dac_d;
      err_q <= err_d;
    end
  end

  assign dac_code = dac_q;
  assign sw_err   = err_q;

endmodule

// File: rtl/sar_afe_model.sv
// Digital stand-in for the SAR analog front end (sample/hold, CDAC, comparator),
// responding to sar_logic so it can be exercised without the analog macro.
//   clk, rst   clock, synchronous active-high reset
//   vin_code   "analog" input voltage as an unsigned code
//   sample     track while high, hold on its falling edge
//   comp_en    comparator strobe
//   sw, swb    DAC switch controls and complements
//   comp_in    comparator decision, COMP_LAT cycles after the strobe, held between strobes
//   held_code  sampled code with OFFSET applied and saturated
//   dac_code   registered DAC code
//   sw_err     sticky illegal-switch-pair flag
//   conv_cnt   completed sample->hold transitions, wraps silently
// COMP_LAT must lie in COMP_LAT_MIN..COMP_LAT_MAX.
module sar_afe_model
  import sar_pkg::*;
#(
  parameter int NBITS     = SAR_NBITS,
  parameter int COMP_LAT  = 1,
  parameter int OFFSET    = 0,
  parameter bit DITHER_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] vin_code,
  input  logic             sample,
  input  logic             comp_en,
  input  logic [NBITS-1:0] sw,
  input  logic [NBITS-1:0] swb,
  output logic             comp_in,
  output logic [NBITS-1:0] held_code,
  output logic [NBITS-1:0] dac_code,
  output logic             sw_err,
  output logic [7:0]       conv_cnt
);

  afe_state_e          state_q;
  logic                sample_q;
  logic [NBITS-1:0]    held_q, held_trk;
  logic [7:0]          conv_q;
  logic [NBITS-1:0]    dac_w;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [COMP_LAT-1:0] vld_q, vld_d, dec_q, dec_d;
  logic                hold_q;
  logic                decision;
  logic                comp_out;

  sar_cdac_decode #(.NBITS(NBITS)) u_cdac (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .swb      (swb),
    .state    (state_q),
    .dac_code (dac_w),
    .sw_err   (sw_err)
  );

  assign held_trk = NBITS'(sat_add(int'(vin_code), OFFSET, (1 << NBITS) - 1));

  // Track/hold FSM with sample-edge counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q  <= HOLD;
      sample_q <= 1'b0;
      held_q   <= '0;
      conv_q   <= '0;
    end else begin
      sample_q <= sample;
      if (sample) held_q <= held_trk;
      case (state_q)
        TRACK: if (!sample && sample_q) begin
          state_q <= HOLD;
          conv_q  <= conv_q + 8'd1;
        end
        HOLD:  if (sample) state_q <= TRACK;
        default: state_q <= HOLD;
      endcase
    end
  end

  // Comparator, latency pipe and dither LFSR (x^8+x^6+x^5+x^4+1).
  always_comb begin
    if (held_q > dac_w)       decision = 1'b1;
    else if (held_q == dac_w) decision = DITHER_EN ? lfsr_q[0] : 1'b1;
    else                      decision = 1'b0;

    lfsr_d = comp_en ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                     : lfsr_q;

    vld_d    = '0;
    dec_d    = '0;
    vld_d[0] = comp_en;
    dec_d[0] = decision;
    for (int i = 1; i < COMP_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dec_d[i] = dec_q[i-1];
    end

    // The last stage is loaded COMP_LAT-1 edges after the strobe edge, so its
    // value is visible exactly COMP_LAT cycles after the comp_en cycle.
    comp_out = vld_q[COMP_LAT-1] ? dec_q[COMP_LAT-1] : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      dec_q  <= '0;
      hold_q <= 1'b0;
      lfsr_q <= 8'hA5;
    end else begin
      vld_q  <= vld_d;
      dec_q  <= dec_d;
      hold_q <= comp_out;
      lfsr_q <= lfsr_d;
    end
  end

  assign comp_in   = comp_out;
  assign held_code = held_q;
  assign dac_code  = dac_w;
  assign conv_cnt  = conv_q;

endmodule

// File: tb/tb_sar_afe_model.sv
// Directed bench for sar_afe_model. Several parameterisations share one
// stimulus stream; each check looks at the instance the scenario targets.
//   inst 0: LAT=1  OFF=0    inst 1: LAT=3  OFF=0    inst 2: LAT=2  OFF=0
//   inst 3: LAT=1  OFF=+5   inst 4: LAT=1  OFF=-5   inst 5: LAT=1  dither
module tb_sar_afe_model;

  localparam int NINST = 6;
  localparam int LAT_P [NINST] = '{1, 3, 2, 1, 1, 1};
  localparam int OFF_P [NINST] = '{0, 0, 0, 5, -5, 0};

  logic       clk;
  logic       rst;
  logic [5:0] vin_code;
  logic       sample;
  logic       comp_en;
  logic [5:0] sw;
  logic [5:0] swb;

  logic       comp_in_w [NINST];
  logic [5:0] held_w    [NINST];
  logic [5:0] dac_w     [NINST];
  logic       sw_err_w  [NINST];
  logic [7:0] conv_w    [NINST];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    sar_afe_model #(
      .NBITS     (6),
      .COMP_LAT  (LAT_P[g]),
      .OFFSET    (OFF_P[g]),
      .DITHER_EN (g == 5)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .vin_code  (vin_code),
      .sample    (sample),
      .comp_en   (comp_en),
      .sw        (sw),
      .swb       (swb),
      .comp_in   (comp_in_w[g]),
      .held_code (held_w[g]),
      .dac_code  (dac_w[g]),
      .sw_err    (sw_err_w[g]),
      .conv_cnt  (conv_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dac(input logic [5:0] v);
    sw  = v;
    swb = ~v;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    sample  = 1'b0;
    comp_en = 1'b0;
    set_dac(6'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic track(input logic [5:0] v, input int n);
    vin_code = v;
    sample   = 1'b1;
    repeat (n) tick();
    sample = 1'b0;
    tick();
  endtask

  logic [5:0] q;
  logic [5:0] trial;
  logic [5:0] exp_bits;

  initial begin
    vin_code = '0;
    do_reset();
    check("rst_comp_in", comp_in_w[0], 0);
    check("rst_held",    held_w[0],    0);
    check("rst_dac",     dac_w[0],     0);
    check("rst_sw_err",  sw_err_w[0],  0);
    check("rst_conv",    conv_w[0],    0);

    // Sample 37 for 3 cycles, then hold.
    track(6'd37, 3);
    check("hold_held", held_w[0], 37);
    check("hold_conv", conv_w[0], 1);
    vin_code = 6'd9;
    tick();
    tick();
    check("hold_frozen", held_w[0], 37);
    check("off_p5_37",   held_w[3], 42);
    check("off_m5_37",   held_w[4], 32);

    // Offset saturation at both rails.
    track(6'd62, 2);
    check("sat_hi", held_w[3], 63);
    check("nosat",  held_w[0], 62);
    track(6'd2, 2);
    check("sat_lo", held_w[4], 0);

    // Closed successive-approximation loop on held=37.
    track(6'd37, 2);
    exp_bits = 6'b100101;
    q = '0;
    for (int b = 5; b >= 0; b--) begin
      trial = q | (6'd1 << b);
      set_dac(trial);
      tick();
      comp_en = 1'b1;
      tick();
      comp_en = 1'b0;
      check($sformatf("loop_bit%0d", b), comp_in_w[0], exp_bits[b]);
      if (comp_in_w[0]) q = trial;
    end
    check("loop_code",   q,           37);
    check("loop_sw_err", sw_err_w[0], 0);

    // sample rising with comp_en: compare uses pre-update held (37 > 30).
    set_dac(6'd30);
    tick();
    vin_code = 6'd0;
    sample   = 1'b1;
    comp_en  = 1'b1;
    tick();
    comp_en = 1'b0;
    sample  = 1'b0;
    check("simul_dec",  comp_in_w[0], 1);
    check("simul_held", held_w[0],    0);
    tick();

    // Latency 3 on an equality compare, plus dither resolution.
    do_reset();
    track(6'd20, 2);
    set_dac(6'b010100);
    tick();
    comp_en = 1'b1;
    tick();
    comp_en = 1'b0;
    check("lat3_c1",  comp_in_w[1], 0);
    check("lat1_eq",  comp_in_w[0], 1);
    check("dith_eq1", comp_in_w[5], 1);
    tick();
    check("lat3_c2", comp_in_w[1], 0);
    tick();
    check("lat3_c3", comp_in_w[1], 1);
    tick();
    check("lat3_keep", comp_in_w[1], 1);
    comp_en = 1'b1;
    tick();
    comp_en = 1'b0;
    check("dith_eq2", comp_in_w[5], 0);
    check("nodith_eq2", comp_in_w[0], 1);

    // Plain decode, then an illegal pair on bit 3 while holding.
    set_dac(6'b101010);
    tick();
    check("dac_decode", dac_w[0], 42);
    sw  = 6'b001000;
    swb = 6'b111111;
    tick();
    check("dac_eq_bit", dac_w[0], 0);
    set_dac(6'd0);
    tick();
    check("sw_err_set", sw_err_w[0], 1);
    repeat (3) tick();
    check("sw_err_sticky", sw_err_w[0], 1);

    // Same pair while tracking is legal.
    do_reset();
    sample = 1'b1;
    tick();
    sw  = 6'b001000;
    swb = 6'b111111;
    tick();
    set_dac(6'd0);
    tick();
    sample = 1'b0;
    tick();
    check("sw_err_track", sw_err_w[0], 0);

    // Back-to-back strobes keep order: 37>32 -> 1, 37<48 -> 0.
    do_reset();
    track(6'd37, 2);
    set_dac(6'd32);
    tick();
    comp_en = 1'b1;
    set_dac(6'd48);
    tick();
    check("b2b_l1_a", comp_in_w[0], 1);
    tick();
    comp_en = 1'b0;
    check("b2b_l1_b", comp_in_w[0], 0);
    check("b2b_l3_0", comp_in_w[1], 0);
    tick();
    check("b2b_l3_a", comp_in_w[1], 1);
    tick();
    check("b2b_l3_b", comp_in_w[1], 0);

    // Reset with two decisions in flight on the latency-2 instance.
    do_reset();
    track(6'd37, 2);
    set_dac(6'd0);
    tick();
    comp_en = 1'b1;
    tick();
    check("mid_inflight", comp_in_w[2], 0);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    comp_en = 1'b0;
    check("mid_rst_comp", comp_in_w[2], 0);
    check("mid_rst_conv", conv_w[2],    0);
    repeat (3) tick();
    check("mid_no_late", comp_in_w[2], 0);

    // conv_cnt wraps after 256 conversions.
    do_reset();
    for (int n = 0; n < 255; n++) begin
      sample = 1'b1;
      tick();
      sample = 1'b0;
      tick();
    end
    check("conv_255", conv_w[0], 255);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    check("conv_wrap", conv_w[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
